gf251_dot_product: RTL and testbench

- Streaming GF(251) inner-product stage that sits directly downstream of gf251_mul and drives it.
- Accepts LEN operand pairs (a_k, b_k) over a valid/ready handshake and issues each pair to an instantiated gf251_mul.
- Accumulates the returned products mod 251 and reports sum(a_k*b_k) mod 251 with a one-cycle done pulse.
- Used for the matrix-vector and polynomial-evaluation steps of the SDitH datapath.

---
 rtl/gf251_pkg.sv | 28 ++
 rtl/gf251_mul.sv | 41 ++++
 rtl/gf251_dot_product.sv | 113 +++++++++++
 tb/tb_gf251_dot_product.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gf251_pkg.sv
// Shared GF(251) definitions: field prime, element type, FSM states and
// the two small reduction helpers used around the multiplier.
package gf251_pkg;

    localparam int unsigned GF_P = 251;

    typedef logic [7:0] gf_elem_t;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } dp_state_t;

    // Sum of two field elements (each 0..250) fits in 9 bits and is below
    // 2*GF_P, so one conditional subtract completes the reduction.
    function automatic gf_elem_t gf251_add_reduce(input logic [8:0] sum);
        return (sum >= 9'(GF_P)) ? 8'(sum - 9'(GF_P)) : sum[7:0];
    endfunction

    // Fold raw byte operands 251..255 into the field.
    function automatic gf_elem_t gf251_reduce_in(input logic [7:0] x);
        return (x >= 8'(GF_P)) ? 8'(x - 8'(GF_P)) : x;
    endfunction

endpackage

// File: rtl/gf251_mul.sv
// Pipelined GF(251) multiplier: a start pulse returns a*b mod 251 together
// with a done pulse LAT cycles later. Operands must already be in 0..250.
module gf251_mul
    import gf251_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     i_clk,
    input  logic     i_start,
    input  gf_elem_t i_a,
    input  gf_elem_t i_b,
    output gf_elem_t o_out,
    output logic     o_done
);

    logic [15:0] prod_full;
    gf_elem_t    prod_mod;
    gf_elem_t    out_q [LAT];
    logic [LAT-1:0] done_q;

    // Full product and its reduction into the field.
    always_comb begin
        prod_full = 16'(i_a) * 16'(i_b);
        prod_mod  = 8'(prod_full % 16'(GF_P));
    end

    // Result/valid pipeline. NOTE: datapath pipeline registers carry no reset;
    // the consumer must ignore done pulses until the pipeline has flushed.
    always_ff @(posedge i_clk) begin
        done_q[0] <= i_start;
        out_q[0]  <= prod_mod;
        for (int i = 1; i < LAT; i++) begin
            done_q[i] <= done_q[i-1];
            out_q[i]  <= out_q[i-1];
        end
    end

    assign o_out  = out_q[LAT-1];
    assign o_done = done_q[LAT-1];

endmodule

// File: rtl/gf251_dot_product.sv
// Streaming GF(251) inner product: accepts LEN operand pairs, issues each to
// gf251_mul, accumulates the products mod 251 and pulses o_done with the sum.
module gf251_dot_product
    import gf251_pkg::*;
#(
    parameter int LEN     = 16,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = $clog2(LEN + 1)
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_start,
    input  logic     i_valid,
    input  gf_elem_t i_a,
    input  gf_elem_t i_b,
    output logic     o_ready,
    output logic     o_busy,
    output gf_elem_t o_result,
    output logic     o_done
);

    localparam int FLUSH_W = $clog2(MUL_LAT + 2);

    dp_state_t        state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] recv_cnt_q;
    gf_elem_t         acc_q;

    logic     accept;
    logic     last_issue;
    logic     all_recv;
    logic     absorb;
    logic     mul_done;
    gf_elem_t mul_out;

    assign o_ready    = (state_q == ST_RUN);
    assign o_busy     = (state_q == ST_FLUSH) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign accept     = i_valid && o_ready;
    assign last_issue = (issue_cnt_q == CNT_W'(LEN - 1));
    assign all_recv   = (recv_cnt_q == CNT_W'(LEN));
    // Products are only meaningful while an operation is in flight.
    assign absorb     = mul_done && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    gf251_mul #(
        .LAT (MUL_LAT)
    ) u_mul (
        .i_clk   (i_clk),
        .i_start (accept),
        .i_a     (gf251_reduce_in(i_a)),
        .i_b     (gf251_reduce_in(i_b)),
        .o_out   (mul_out),
        .o_done  (mul_done)
    );

    // State register. NOTE: all sequential state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_FLUSH;
        else          state_q <= state_d;
    end

    // Next-state logic. NOTE: state_d is defaulted first so no path through
    // the case leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FLUSH: if (flush_cnt_q <= FLUSH_W'(1)) state_d = ST_IDLE;
            ST_IDLE,
            ST_DONE:  if (i_start)                    state_d = ST_RUN;
            ST_RUN:   if (accept && last_issue)       state_d = ST_DRAIN;
            ST_DRAIN: if (all_recv)                   state_d = ST_DONE;
            default:                                  state_d = ST_FLUSH;
        endcase
    end

    // Flush counter, issue/receive counters, accumulator and result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_cnt_q <= FLUSH_W'(MUL_LAT + 1);
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            acc_q       <= '0;
            o_result    <= '0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;

            if (state_q == ST_FLUSH && flush_cnt_q != '0)
                flush_cnt_q <= flush_cnt_q - FLUSH_W'(1);

            if ((state_q == ST_IDLE || state_q == ST_DONE) && i_start) begin
                issue_cnt_q <= '0;
                recv_cnt_q  <= '0;
                acc_q       <= '0;
            end

            if (accept)
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);

            if (absorb) begin
                acc_q      <= gf251_add_reduce({1'b0, acc_q} + {1'b0, mul_out});
                recv_cnt_q <= recv_cnt_q + CNT_W'(1);
            end

            if (state_q == ST_DRAIN && all_recv) begin
                o_result <= acc_q;
                o_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gf251_dot_product.sv
// Self-checking bench for gf251_dot_product (LEN=3): a plain-arithmetic model
// of the inner product is checked against o_done/o_result every cycle, and
// directed runs pin results, latency and reset behaviour to literal values.
module tb_gf251_dot_product;

    localparam int TB_LEN  = 3;
    localparam int TB_LAT  = 1;
    localparam int TIMEOUT = 40;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic       o_ready;
    logic       o_busy;
    logic [7:0] o_result;
    logic       o_done;

    int checks = 0;
    int passes = 0;

    // Model state: running sum of the current group of LEN accepted pairs.
    int edge_cnt   = 0;
    int model_pairs = 0;
    int model_sum  = 0;
    int model_last = 0;
    int done_due   = -1;
    int pa [TB_LEN];
    int pb [TB_LEN];

    gf251_dot_product #(
        .LEN     (TB_LEN),
        .MUL_LAT (TB_LAT)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_result (o_result),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int fold(input int x);
        return (x >= 251) ? x - 251 : x;
    endfunction

    // Model update on each rising edge, from the values present at the edge.
    always @(posedge i_clk) begin
        edge_cnt <= edge_cnt + 1;
        if (!i_rst_n) begin
            model_pairs <= 0;
            model_sum   <= 0;
            done_due    <= -1;
        end else if (i_valid && o_ready) begin
            if (model_pairs == TB_LEN - 1) begin
                model_last  <= (model_sum + fold(i_a) * fold(i_b)) % 251;
                model_sum   <= 0;
                model_pairs <= 0;
                done_due    <= edge_cnt + 1 + TB_LAT + 1;
            end else begin
                model_sum   <= (model_sum + fold(i_a) * fold(i_b)) % 251;
                model_pairs <= model_pairs + 1;
            end
        end
    end

    // Every cycle out of reset: o_done pulses exactly when due, with the sum.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check("done_pulse", int'(o_done), int'(edge_cnt == done_due));
            if (edge_cnt == done_due)
                check("model_result", int'(o_result), model_last);
        end
    end

    task automatic check_reset_outputs();
        check("rst_ready",  int'(o_ready),  0);
        check("rst_busy",   int'(o_busy),   1);
        check("rst_done",   int'(o_done),   0);
        check("rst_result", int'(o_result), 0);
    endtask

    // Release reset on a falling edge and count cycles until o_busy drops.
    task automatic release_and_flush();
        int n;
        i_rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_busy && n < TIMEOUT);
        check("flush_cycles", n, TB_LAT + 1);
    endtask

    // One dot product over pa/pb; optional gaps with a start poke, optional
    // abort (reset asserted right after the last accept, mid-DRAIN).
    task automatic run_op(input string name, input int gap, input bit poke,
                          input bit abort, input int exp_res);
        int waited;
        int last_edge;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < TB_LEN; k++) begin
            if (k > 0 && gap > 0) begin
                i_valid = 1'b0;
                i_start = poke;
                @(negedge i_clk);
                i_start = 1'b0;
                repeat (gap - 1) @(negedge i_clk);
            end
            i_valid = 1'b1;
            i_a = 8'(pa[k]);
            i_b = 8'(pb[k]);
            waited = 0;
            while (!o_ready && waited < TIMEOUT) begin
                @(negedge i_clk);
                waited++;
            end
            if (waited >= TIMEOUT) check({name, "_ready_timeout"}, 0, 1);
            @(negedge i_clk);
            last_edge = edge_cnt;
        end
        i_valid = 1'b0;
        if (abort) begin
            i_rst_n = 1'b0;
            return;
        end
        waited = 0;
        while (!o_done && waited < TIMEOUT) begin
            @(negedge i_clk);
            waited++;
        end
        check({name, "_latency"}, edge_cnt - last_edge, TB_LAT + 1);
        check({name, "_result"}, int'(o_result), exp_res);
        check({name, "_model_pin"}, model_last, exp_res);
        @(negedge i_clk);
        check({name, "_busy_after"}, int'(o_busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_reset_outputs();
        release_and_flush();

        pa = '{1, 34, 62};    pb = '{20, 31, 85};
        run_op("basic", 0, 1'b0, 1'b0, 69);

        pa = '{250, 250, 250}; pb = '{250, 250, 250};
        run_op("minus_one", 0, 1'b0, 1'b0, 3);

        pa = '{250, 250, 1};   pb = '{1, 1, 1};
        run_op("wrap", 0, 1'b0, 1'b0, 250);

        pa = '{255, 0, 0};     pb = '{10, 0, 0};
        run_op("reduce_in", 0, 1'b0, 1'b0, 40);

        pa = '{1, 34, 62};    pb = '{20, 31, 85};
        run_op("gapped", 2, 1'b1, 1'b0, 69);

        run_op("abort", 0, 1'b0, 1'b1, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_outputs();
        release_and_flush();

        pa = '{2, 0, 0};       pb = '{3, 0, 0};
        run_op("after_reset", 0, 1'b0, 1'b0, 6);

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
